// File: rtl/eltwise_requant_unit.sv
// eltwise_requant_unit: LANES-wide int8 elementwise op with Q31 requantisation and saturation.
// Define ELTWISE_SATCNT_EN to count clamped lanes on sat_cnt; otherwise sat_cnt is tied to 0.
module eltwise_requant_unit #(
    parameter int LANES     = 4,
    parameter int IDX_WIDTH = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*8-1:0]     in_a,
    input  logic [LANES*8-1:0]     in_b,
    input  logic [1:0]             cfg_op,
    input  logic [31:0]            cfg_a_zp,
    input  logic [31:0]            cfg_b_zp,
    input  logic [31:0]            cfg_mult,
    input  logic [4:0]             cfg_shift,
    input  logic [31:0]            cfg_out_zp,
    input  logic [IDX_WIDTH-1:0]   cfg_len,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*8-1:0]     out_data,
    output logic [IDX_WIDTH-1:0]   out_idx,
    output logic                   out_last,
    output logic [15:0]            sat_cnt
);
    // 66 bits holds the exact product of two 33-bit zero-point-corrected operands
    localparam int XW = 66;
    localparam int PW = XW + 32;
    localparam int ZW = PW + 1;
    localparam logic signed [ZW-1:0] ZMAX = 127;
    localparam logic signed [ZW-1:0] ZMIN = -128;

    logic                        w_en;
    logic                        w_wrap;
    logic                        r_v0, r_v1, r_v2, r_ov;
    logic [LANES*8-1:0]          r_a0, r_b0, r_data, w_dat;
    logic [1:0]                  r_op0;
    logic [31:0]                 r_azp0, r_bzp0;
    logic signed [XW-1:0]        r_x1 [LANES];
    logic signed [PW-1:0]        r_y2 [LANES];
    logic signed [ZW-1:0]        w_z  [LANES];
    logic [IDX_WIDTH-1:0]        r_idx;

    function automatic logic signed [XW-1:0] f_op(input logic [7:0] a, input logic [7:0] b,
                                                  input logic [1:0] op, input logic [31:0] azp,
                                                  input logic [31:0] bzp);
        logic signed [XW-1:0] ea, eb;
        ea = XW'($signed(a)) - XW'($signed(azp));
        eb = XW'($signed(b)) - XW'($signed(bzp));
        return op == 2'd0 ? ea : op == 2'd1 ? ea + eb : op == 2'd2 ? ea * eb : (ea[XW-1] ? '0 : ea);
    endfunction

    function automatic logic signed [PW-1:0] f_rq(input logic signed [XW-1:0] x,
                                                  input logic [31:0] m, input logic [4:0] sh);
        logic signed [PW-1:0] p, r;
        p = PW'(x) * PW'($signed(m));
        r = '0;
        r[7'd30 + 7'(sh)] = 1'b1;
        return (p + r) >>> (7'd31 + 7'(sh));
    endfunction

    function automatic logic signed [ZW-1:0] f_z(input logic signed [PW-1:0] y, input logic [31:0] zp);
        return ZW'(y) + ZW'($signed(zp));
    endfunction

    assign w_en      = !r_ov || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_ov;
    assign out_data  = r_data;
    assign out_idx   = r_idx;
    assign w_wrap    = (cfg_len != '0) && (r_idx == cfg_len - 1'b1);
    assign out_last  = r_ov && w_wrap;

    always_comb begin
        w_dat = '0;
        w_z   = '{default: '0};
        for (int i = 0; i < LANES; i++) begin
            w_z[i]         = f_z(r_y2[i], cfg_out_zp);
            w_dat[8*i +: 8] = w_z[i] > ZMAX ? 8'h7F : w_z[i] < ZMIN ? 8'h80 : w_z[i][7:0];
        end
    end

    // Datapath registers carry no reset; their valids gate everything downstream
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_a0   <= in_a;
            r_b0   <= in_b;
            r_op0  <= cfg_op;
            r_azp0 <= cfg_a_zp;
            r_bzp0 <= cfg_b_zp;
            for (int i = 0; i < LANES; i++) begin
                r_x1[i] <= f_op(r_a0[8*i +: 8], r_b0[8*i +: 8], r_op0, r_azp0, r_bzp0);
                r_y2[i] <= f_rq(r_x1[i], cfg_mult, cfg_shift);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0   <= 1'b0;
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_ov   <= 1'b0;
            r_data <= '0;
            r_idx  <= '0;
        end else begin
            if (w_en) begin
                r_v0   <= in_valid;
                r_v1   <= r_v0;
                r_v2   <= r_v1;
                r_ov   <= r_v2;
                r_data <= w_dat;
            end
            if (r_ov && out_ready)
                r_idx <= w_wrap ? '0 : r_idx + 1'b1;
        end
    end

`ifdef ELTWISE_SATCNT_EN
    logic [LANES-1:0] r_sat3, w_sat;
    logic [15:0]      r_cnt;
    logic [16:0]      w_sum;

    always_comb begin
        w_sat = '0;
        w_sum = {1'b0, r_cnt};
        for (int i = 0; i < LANES; i++) begin
            w_sat[i] = w_z[i] > ZMAX || w_z[i] < ZMIN;
            w_sum    = w_sum + 17'(r_sat3[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat3 <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_en)
                r_sat3 <= w_sat;
            if (r_ov && out_ready)
                r_cnt <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
        end
    end

    assign sat_cnt = r_cnt;
`else
    assign sat_cnt = '0;
`endif
endmodule

// File: tb/tb_eltwise_requant_unit.sv
// tb_eltwise_requant_unit: directed checks of eltwise_requant_unit with LANES=4.
module tb_eltwise_requant_unit;
    localparam int IW = 18;
`ifdef ELTWISE_SATCNT_EN
    localparam bit SATEN = 1'b1;
`else
    localparam bit SATEN = 1'b0;
`endif

    typedef struct {
        logic [31:0] a, b, azp, bzp, exp;
        logic [1:0]  op;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready, out_last;
    logic [31:0]   in_a, in_b, cfg_a_zp, cfg_b_zp, cfg_mult, cfg_out_zp, out_data;
    logic [1:0]    cfg_op;
    logic [4:0]    cfg_shift;
    logic [IW-1:0] cfg_len, out_idx;
    logic [15:0]   sat_cnt;

    beat_t         inq[$];
    beat_t         expq[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            sat_exp = 0;
    int            n_last  = 0;
    logic [IW-1:0] m_idx   = '0;

    eltwise_requant_unit #(.LANES(4), .IDX_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .cfg_op(cfg_op), .cfg_a_zp(cfg_a_zp), .cfg_b_zp(cfg_b_zp),
        .cfg_mult(cfg_mult), .cfg_shift(cfg_shift), .cfg_out_zp(cfg_out_zp), .cfg_len(cfg_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .sat_cnt(sat_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [31:0] azp, input logic [31:0] bzp, input logic [31:0] exp);
        beat_t t;
        t.a = a; t.b = b; t.op = op; t.azp = azp; t.bzp = bzp; t.exp = exp;
        inq.push_back(t);
        expq.push_back(t);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        m_idx = '0;
        sat_exp = 0;
    endtask

    // Drives queued beats, drains expected results, and checks handshake/stall behaviour
    task automatic run(input int stall_at, input int stall_len);
        int          c = 0;
        bit          hold = 1'b0;
        bit          saw_low = 1'b0;
        logic [51:0] held = '0;
        logic        m_last;
        beat_t       e;
        while ((inq.size() != 0 || expq.size() != 0) && c < 200) begin
            out_ready = !(c >= stall_at && c < stall_at + stall_len);
            in_valid = inq.size() != 0;
            if (in_valid) begin
                in_a = inq[0].a; in_b = inq[0].b; cfg_op = inq[0].op;
                cfg_a_zp = inq[0].azp; cfg_b_zp = inq[0].bzp;
            end
            #1;
            chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            if (!in_ready) saw_low = 1'b1;
            if (hold) chk("stall_hold", 64'({out_valid, out_last, out_idx, out_data}), 64'(held));
            hold = out_valid && !out_ready;
            held = {out_valid, out_last, out_idx, out_data};
            if (out_valid && out_ready) begin
                m_last = cfg_len != '0 && m_idx == cfg_len - 1'b1;
                if (expq.size() == 0) chk("extra_beat", 64'(expq.size()), 64'd1);
                else begin
                    e = expq.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.exp));
                    chk("out_idx", 64'(out_idx), 64'(m_idx));
                    chk("out_last", 64'(out_last), 64'(m_last));
                    if (out_last) n_last++;
                end
                m_idx = m_last ? '0 : m_idx + 1'b1;
            end
            if (in_valid && in_ready) void'(inq.pop_front());
            tick();
            c++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (stall_len > 0) chk("stall_in_ready_low", 64'(saw_low), 64'd1);
        chk("run_in_budget", 64'(c < 200), 64'd1);
    endtask

    initial begin
        logic [31:0] va, vb, ve;
        in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0; cfg_op = 2'd0;
        cfg_a_zp = '0; cfg_b_zp = '0; cfg_mult = 32'h4000_0000; cfg_shift = 5'd0;
        cfg_out_zp = '0; cfg_len = '0; rst = 1'b1;
        do_reset();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // ADD 10+20 -> 15, visible exactly three edges after the accepting edge
        cfg_op = 2'd1; in_a = 32'h0A0A0A0A; in_b = 32'h14141414; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_edge0", 64'(out_valid), 64'd0);
        tick();
        chk("lat_edge1", 64'(out_valid), 64'd0);
        tick();
        chk("lat_edge2", 64'(out_valid), 64'd0);
        tick();
        chk("lat_edge3", 64'(out_valid), 64'd1);
        chk("add_data", 64'(out_data), 64'h0F0F0F0F);
        chk("add_idx", 64'(out_idx), 64'd0);
        tick();
        m_idx = m_idx + 1'b1;
        chk("add_drained", 64'(out_valid), 64'd0);

        cfg_shift = 5'd6;
        push(32'h9C646464, 32'h64646464, 2'd2, 0, 0, 32'hB24E4E4E);
        run(999, 0);
        cfg_shift = 5'd0;
        push(32'hFD03FD03, 32'h0, 2'd0, 0, 0, 32'hFF02FF02);
        run(999, 0);
        cfg_out_zp = 32'd5;
        push(32'hFF0014CE, 32'h7F7F7F7F, 2'd3, 0, 0, 32'h05050F05);
        run(999, 0);
        chk("sat_none_yet", 64'(sat_cnt), 64'd0);

        cfg_out_zp = 32'd10;
        push(32'h7F7F7F7F, 32'h7F7F7F7F, 2'd1, 0, 0, 32'h7F7F7F7F);
        run(999, 0);
        sat_exp += 4;
        chk("sat_pos", 64'(sat_cnt), SATEN ? 64'(sat_exp) : 64'd0);
        cfg_out_zp = 32'hFFFF_FFFF;
        push(32'h00008080, 32'h00008080, 2'd1, 0, 0, 32'hFFFF8080);
        run(999, 0);
        sat_exp += 2;
        chk("sat_neg", 64'(sat_cnt), SATEN ? 64'(sat_exp) : 64'd0);
        cfg_out_zp = 32'd0;
        push(32'h80808080, 32'h80808080, 2'd1, 0, 0, 32'h80808080);
        run(999, 0);
        chk("sat_boundary", 64'(sat_cnt), SATEN ? 64'(sat_exp) : 64'd0);

        // Per-beat zero points: x = (a-k)+(b-k) = 2k+2j, result k+j
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 4; j++) begin
                va[8*j +: 8] = 8'(3*k + 2*j);
                vb[8*j +: 8] = 8'(k);
                ve[8*j +: 8] = 8'(k + j);
            end
            push(va, vb, 2'd1, 32'(k), 32'(k), ve);
        end
        run(5, 5);

        do_reset();
        chk("rst2_sat_cnt", 64'(sat_cnt), 64'd0);
        chk("rst2_out_idx", 64'(out_idx), 64'd0);
        cfg_len = 18'd3;
        n_last = 0;
        for (int k = 0; k < 7; k++) push({4{8'(2*k)}}, 32'h0, 2'd0, 0, 0, {4{8'(k)}});
        run(999, 0);
        chk("last_count", 64'(n_last), 64'd2);

        cfg_len = '0;
        cfg_op = 2'd0; cfg_a_zp = '0; cfg_b_zp = '0; in_a = 32'h11111111; in_valid = 1'b1;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_idx = '0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("flush_no_emit", 64'(out_valid), 64'd0);
        end
        push(32'h0A0A0A0A, 32'h0, 2'd0, 0, 0, 32'h05050505);
        run(999, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
